alu_unit: RTL and testbench

Execution stage directly downstream of the reservation station. Each cycle it takes the issued operation (op, Vj, Vk, imm, pc, rob tag), computes the integer result and branch outcome, and drives the registered ALU CDB broadcast that the ROB and reservation stations snoop. It also provides an optional iterative multiplier, and raises `out_busy` to stall issue while a multiply is in flight.

---
 rtl/alu_unit_pkg.sv | 114 +++++++++++
 rtl/alu_unit_if.sv | 32 +++
 rtl/alu_unit_mul_iter.sv | 62 ++++++
 rtl/alu_unit.sv | 148 ++++++++++++++
 tb/tb_alu_unit.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_unit_pkg.sv
// Shared constants for alu_unit: bus widths, operation encodings (MUL-class
// included), the FSM state type and the single-cycle evaluation function.
package alu_unit_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int ROB_WIDTH     = 5;
  localparam int OPERATION_BUS = 6;

  localparam logic [ROB_WIDTH-1:0] ZERO_ROB = '0;

  typedef logic [OPERATION_BUS-1:0] op_t;

  localparam op_t OP_NOP    = 6'd0;
  localparam op_t OP_ADD    = 6'd1;
  localparam op_t OP_SUB    = 6'd2;
  localparam op_t OP_AND    = 6'd3;
  localparam op_t OP_OR     = 6'd4;
  localparam op_t OP_XOR    = 6'd5;
  localparam op_t OP_SLL    = 6'd6;
  localparam op_t OP_SRL    = 6'd7;
  localparam op_t OP_SRA    = 6'd8;
  localparam op_t OP_SLT    = 6'd9;
  localparam op_t OP_SLTU   = 6'd10;
  localparam op_t OP_ADDI   = 6'd11;
  localparam op_t OP_ANDI   = 6'd12;
  localparam op_t OP_ORI    = 6'd13;
  localparam op_t OP_XORI   = 6'd14;
  localparam op_t OP_SLLI   = 6'd15;
  localparam op_t OP_SRLI   = 6'd16;
  localparam op_t OP_SRAI   = 6'd17;
  localparam op_t OP_SLTI   = 6'd18;
  localparam op_t OP_SLTIU  = 6'd19;
  localparam op_t OP_LUI    = 6'd20;
  localparam op_t OP_AUIPC  = 6'd21;
  localparam op_t OP_JAL    = 6'd22;
  localparam op_t OP_JALR   = 6'd23;
  localparam op_t OP_BEQ    = 6'd24;
  localparam op_t OP_BNE    = 6'd25;
  localparam op_t OP_BLT    = 6'd26;
  localparam op_t OP_BGE    = 6'd27;
  localparam op_t OP_BLTU   = 6'd28;
  localparam op_t OP_BGEU   = 6'd29;
  localparam op_t OP_MUL    = 6'd30;
  localparam op_t OP_MULH   = 6'd31;
  localparam op_t OP_MULHSU = 6'd32;
  localparam op_t OP_MULHU  = 6'd33;

  typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} alu_state_e;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  br_valid;
    logic                  br_taken;
    logic [DATA_WIDTH-1:0] br_target;
  } alu_res_t;

  function automatic logic is_mul_op(op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  // Single-cycle result of any non-multiplying op. MUL-class ops report
  // valid with data 0; the top decides whether the multiplier overrides.
  function automatic alu_res_t alu_eval(op_t op, logic [31:0] vj, logic [31:0] vk,
                                        logic [31:0] imm, logic [31:0] pc);
    alu_res_t   r;
    logic [31:0] b;
    logic [4:0]  sh;
    logic        taken;
    r     = '0;
    r.valid = 1'b1;
    taken = 1'b0;
    b     = (op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI,
                        OP_SRAI, OP_SLTI, OP_SLTIU}) ? imm : vk;
    sh    = b[4:0];
    case (op)
      OP_ADD, OP_ADDI:   r.data = vj + b;
      OP_SUB:            r.data = vj - vk;
      OP_AND, OP_ANDI:   r.data = vj & b;
      OP_OR, OP_ORI:     r.data = vj | b;
      OP_XOR, OP_XORI:   r.data = vj ^ b;
      OP_SLL, OP_SLLI:   r.data = vj << sh;
      OP_SRL, OP_SRLI:   r.data = vj >> sh;
      OP_SRA, OP_SRAI:   r.data = $signed(vj) >>> sh;
      OP_SLT, OP_SLTI:   r.data = {31'd0, $signed(vj) < $signed(b)};
      OP_SLTU, OP_SLTIU: r.data = {31'd0, vj < b};
      OP_LUI:            r.data = imm;
      OP_AUIPC:          r.data = pc + imm;
      OP_JAL, OP_JALR: begin
        r.data      = pc + 32'd4;
        r.br_valid  = 1'b1;
        r.br_taken  = 1'b1;
        r.br_target = (op == OP_JAL) ? (pc + imm) : ((vj + imm) & ~32'd1);
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        case (op)
          OP_BEQ:  taken = (vj == vk);
          OP_BNE:  taken = (vj != vk);
          OP_BLT:  taken = ($signed(vj) < $signed(vk));
          OP_BGE:  taken = ($signed(vj) >= $signed(vk));
          OP_BLTU: taken = (vj < vk);
          default: taken = (vj >= vk);
        endcase
        r.br_valid  = 1'b1;
        r.br_taken  = taken;
        r.br_target = taken ? (pc + imm) : (pc + 32'd4);
      end
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: r.data = '0;
      default:           r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_unit_if.sv
// Issue/broadcast bundle between reservation station, alu_unit and CDB.
// Handshake: an issue is valid when in_op != NOP; the ALU is ready when
// out_busy is low; the op is consumed at a rising edge with ena high and
// out_busy low. Ops presented while out_busy is high are dropped.
interface alu_unit_if;
  import alu_unit_pkg::*;

  logic [OPERATION_BUS-1:0] in_op;
  logic [DATA_WIDTH-1:0]    in_Vj;
  logic [DATA_WIDTH-1:0]    in_Vk;
  logic [DATA_WIDTH-1:0]    in_imm;
  logic [DATA_WIDTH-1:0]    in_pc;
  logic [ROB_WIDTH-1:0]     in_rob_tag;
  logic [ROB_WIDTH-1:0]     out_cdb_rob_tag;
  logic [DATA_WIDTH-1:0]    out_cdb_data;
  logic                     out_br_valid;
  logic                     out_br_taken;
  logic [DATA_WIDTH-1:0]    out_br_target;
  logic                     out_busy;

  modport master (
    output in_op, in_Vj, in_Vk, in_imm, in_pc, in_rob_tag,
    input  out_cdb_rob_tag, out_cdb_data, out_br_valid, out_br_taken,
           out_br_target, out_busy
  );

  modport slave (
    input  in_op, in_Vj, in_Vk, in_imm, in_pc, in_rob_tag,
    output out_cdb_rob_tag, out_cdb_data, out_br_valid, out_br_taken,
           out_br_target, out_busy
  );
endinterface

// File: rtl/alu_unit_mul_iter.sv
// alu_mul_iter: radix-2 shift-add multiplier on operand magnitudes with a
// sign fix-up at the end. start loads operands; each run cycle does one
// iteration; done is high during the cycle whose edge performs the last
// iteration, and result already reflects that final step.
module alu_mul_iter
  import alu_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        run,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        a_signed,
  input  logic        b_signed,
  input  logic        hi_sel,
  output logic        done,
  output logic [31:0] result
);
  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      prod_q;
  logic [31:0]      mcand_q;
  logic             negate_q;
  logic             hi_q;
  logic [32:0]      sum;
  logic [63:0]      prod_step;
  logic [63:0]      prod_fixed;

  // One iteration: conditionally add the multiplicand to the upper half,
  // then shift the whole product right; the multiplier drains from the LSBs.
  always_comb begin
    sum        = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
    prod_step  = {sum, prod_q[31:1]};
    prod_fixed = negate_q ? (~prod_step + 64'd1) : prod_step;
    result     = hi_q ? prod_fixed[63:32] : prod_fixed[31:0];
    done       = run && (cnt_q == CNT_W'(MUL_CYCLES - 1));
  end

  // Operand load on start, iteration and count while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      negate_q <= 1'b0;
      hi_q     <= 1'b0;
    end else if (start) begin
      cnt_q    <= '0;
      mcand_q  <= (a_signed && a[31]) ? (~a + 32'd1) : a;
      prod_q   <= {32'd0, (b_signed && b[31]) ? (~b + 32'd1) : b};
      negate_q <= (a_signed && a[31]) ^ (b_signed && b[31]);
      hi_q     <= hi_sel;
    end else if (run) begin
      cnt_q  <= cnt_q + 1'b1;
      prod_q <= prod_step;
    end
  end
endmodule

// File: rtl/alu_unit.sv
// alu_unit: execution stage behind the reservation station. Computes the
// integer/branch result of the issued op and drives the registered ALU CDB
// broadcast. Optional feature macro ALU_MUL_EN adds the iterative multiplier
// (MUL, MULH, MULHSU, MULHU) and the IDLE/MUL state machine; without it,
// MUL-class ops broadcast data 0 and out_busy is tied low.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  alu_unit_if.slave  bus,
  output alu_state_e dbg_state
);
  if (MUL_CYCLES < 1) begin : g_bad_mul_cycles
    $error("MUL_CYCLES must be at least 1");
  end

  alu_res_t              res;
  logic [ROB_WIDTH-1:0]  tag_d, tag_q;
  logic [DATA_WIDTH-1:0] data_d, data_q;
  logic                  brv_d, brv_q;
  logic                  brt_d, brt_q;
  logic [DATA_WIDTH-1:0] tgt_d, tgt_q;

  assign res = alu_eval(bus.in_op, bus.in_Vj, bus.in_Vk, bus.in_imm, bus.in_pc);

`ifdef ALU_MUL_EN
  alu_state_e           state_q, state_d;
  logic                 start_req, mul_start, mul_run, mul_done;
  logic [31:0]          mul_result;
  logic [ROB_WIDTH-1:0] mul_tag_q;

  assign start_req = (state_q == ST_IDLE) && is_mul_op(bus.in_op);

  // State register; frozen while ena is low.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else if (ena) state_q <= state_d;
  end

  // Next state: IDLE -> MUL on a MUL-class op, back once the last iteration runs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_req) state_d = ST_MUL;
      ST_MUL:  if (mul_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: multiplier control and the next broadcast. in_op is ignored in MUL.
  always_comb begin
    mul_start = ena && start_req;
    mul_run   = ena && (state_q == ST_MUL);
    tag_d     = ZERO_ROB;
    data_d    = '0;
    brv_d     = 1'b0;
    brt_d     = 1'b0;
    tgt_d     = '0;
    if (state_q == ST_MUL) begin
      if (mul_done) begin
        tag_d  = mul_tag_q;
        data_d = mul_result;
      end
    end else if (!start_req && res.valid) begin
      tag_d  = bus.in_rob_tag;
      data_d = res.data;
      brv_d  = res.br_valid;
      brt_d  = res.br_taken;
      tgt_d  = res.br_target;
    end
  end

  // Destination tag of the multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) mul_tag_q <= ZERO_ROB;
    else if (mul_start) mul_tag_q <= bus.in_rob_tag;
  end

  // An op presented while busy is a reservation-station protocol error.
  always_ff @(posedge clk) begin
    if (!rst && ena && state_q == ST_MUL)
      assert (bus.in_op == OP_NOP) else $error("alu_unit: issue while busy, op dropped");
  end

  alu_mul_iter #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start    (mul_start),
    .run      (mul_run),
    .a        (bus.in_Vj),
    .b        (bus.in_Vk),
    .a_signed (bus.in_op == OP_MULH || bus.in_op == OP_MULHSU),
    .b_signed (bus.in_op == OP_MULH),
    .hi_sel   (bus.in_op != OP_MUL),
    .done     (mul_done),
    .result   (mul_result)
  );

  assign bus.out_busy = (state_q == ST_MUL);
  assign dbg_state    = state_q;
`else
  // Next broadcast straight from the single-cycle evaluation.
  always_comb begin
    tag_d  = ZERO_ROB;
    data_d = '0;
    brv_d  = 1'b0;
    brt_d  = 1'b0;
    tgt_d  = '0;
    if (res.valid) begin
      tag_d  = bus.in_rob_tag;
      data_d = res.data;
      brv_d  = res.br_valid;
      brt_d  = res.br_taken;
      tgt_d  = res.br_target;
    end
  end

  assign bus.out_busy = 1'b0;
  assign dbg_state    = ST_IDLE;
`endif

  // Registered CDB broadcast; holds while ena is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q  <= ZERO_ROB;
      data_q <= '0;
      brv_q  <= 1'b0;
      brt_q  <= 1'b0;
      tgt_q  <= '0;
    end else if (ena) begin
      tag_q  <= tag_d;
      data_q <= data_d;
      brv_q  <= brv_d;
      brt_q  <= brt_d;
      tgt_q  <= tgt_d;
    end
  end

  assign bus.out_cdb_rob_tag = tag_q;
  assign bus.out_cdb_data    = data_q;
  assign bus.out_br_valid    = brv_q;
  assign bus.out_br_taken    = brt_q;
  assign bus.out_br_target   = tgt_q;
endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed cases, randomized ops against a
// behavioural model, enable freeze, and (with ALU_MUL_EN) multiplier timing.
module tb_alu_unit;
  import alu_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  alu_state_e dbg_state;
  int         n_cmp = 0;
  int         n_fail = 0;

  alu_unit_if bus ();

  alu_unit #(.MUL_CYCLES(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] data;
    logic        br_valid;
    logic        br_taken;
    logic [31:0] target;
    bit          chk_data;
    bit          chk_br;
  } exp_t;

  op_t alu_ops[$] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL,
                      OP_SRA, OP_SLT, OP_SLTU, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
                      OP_SLLI, OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU, OP_LUI,
                      OP_AUIPC, OP_JAL, OP_JALR, OP_BEQ, OP_BNE, OP_BLT, OP_BGE,
                      OP_BLTU, OP_BGEU, OP_NOP};
  op_t mul_ops[$] = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};

  // Reference: results from the ISA rules using 64-bit arithmetic.
  function automatic exp_t ref_model(op_t op, logic [31:0] vj, logic [31:0] vk,
                                     logic [31:0] imm, logic [31:0] pc, logic [4:0] tag);
    exp_t e;
    longint sj, sb, sk;
    longint unsigned uj, ub, uk;
    logic [31:0] b;
    bit taken;
    e = '{tag: tag, data: 32'd0, br_valid: 1'b0, br_taken: 1'b0, target: 32'd0,
          chk_data: 1'b1, chk_br: 1'b0};
    b  = (op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI, OP_SRAI,
                     OP_SLTI, OP_SLTIU}) ? imm : vk;
    sj = longint'($signed(vj)); sk = longint'($signed(vk)); sb = longint'($signed(b));
    uj = {32'd0, vj}; uk = {32'd0, vk}; ub = {32'd0, b};
    taken = 0;
    case (op)
      OP_ADD, OP_ADDI:   e.data = 32'(uj + ub);
      OP_SUB:            e.data = 32'(uj - uk);
      OP_AND, OP_ANDI:   e.data = vj & b;
      OP_OR, OP_ORI:     e.data = vj | b;
      OP_XOR, OP_XORI:   e.data = vj ^ b;
      OP_SLL, OP_SLLI:   e.data = 32'(uj << b[4:0]);
      OP_SRL, OP_SRLI:   e.data = 32'(uj >> b[4:0]);
      OP_SRA, OP_SRAI:   e.data = 32'(sj >>> b[4:0]);
      OP_SLT, OP_SLTI:   e.data = (sj < sb) ? 32'd1 : 32'd0;
      OP_SLTU, OP_SLTIU: e.data = (uj < ub) ? 32'd1 : 32'd0;
      OP_LUI:            e.data = imm;
      OP_AUIPC:          e.data = pc + imm;
      OP_JAL, OP_JALR: begin
        e.data = pc + 32'd4; e.br_valid = 1; e.br_taken = 1; e.chk_br = 1;
        e.target = (op == OP_JAL) ? pc + imm : ((vj + imm) & 32'hFFFF_FFFE);
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        if (op == OP_BEQ)  taken = (uj == uk);
        if (op == OP_BNE)  taken = (uj != uk);
        if (op == OP_BLT)  taken = (sj < sk);
        if (op == OP_BGE)  taken = (sj >= sk);
        if (op == OP_BLTU) taken = (uj < uk);
        if (op == OP_BGEU) taken = (uj >= uk);
        e.data = 0; e.br_valid = 1; e.br_taken = taken; e.chk_br = 1;
        e.target = taken ? pc + imm : pc + 32'd4;
      end
`ifdef ALU_MUL_EN
      OP_MUL:    e.data = 32'(uj * uk);
      OP_MULH:   e.data = 32'((sj * sk) >>> 32);
      OP_MULHSU: e.data = 32'((sj * longint'(uk)) >>> 32);
      OP_MULHU:  e.data = 32'((uj * uk) >> 32);
`else
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: e.data = 32'd0;
`endif
      default: begin e.tag = 5'd0; e.chk_data = 0; end
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Driver: present an op; caller advances the clock.
  task automatic drive(input op_t op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] tag);
    bus.in_op = op; bus.in_Vj = vj; bus.in_Vk = vk;
    bus.in_imm = imm; bus.in_pc = pc; bus.in_rob_tag = tag;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_out(input string name, input exp_t e);
    chk({name, ".tag"}, 32'(bus.out_cdb_rob_tag), 32'(e.tag));
    chk({name, ".br_valid"}, 32'(bus.out_br_valid), 32'(e.br_valid));
    chk({name, ".busy"}, 32'(bus.out_busy), 32'd0);
    if (e.chk_data) chk({name, ".data"}, bus.out_cdb_data, e.data);
    if (e.chk_br) begin
      chk({name, ".taken"}, 32'(bus.out_br_taken), 32'(e.br_taken));
      chk({name, ".target"}, bus.out_br_target, e.target);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

`ifdef ALU_MUL_EN
  // Multiply: busy for MUL_CYCLES active edges (plus frozen edges), idle CDB
  // meanwhile, then one result cycle with busy low.
  task automatic run_mul(input op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input int freeze_at, input int freeze_len);
    exp_t e;
    e = ref_model(op, a, b, 32'd0, 32'd0, tag);
    drive(op, a, b, 32'd0, 32'd0, tag);
    step();
    bus.in_op = OP_NOP;
    for (int j = 0; j < 32; j++) begin
      chk("mul.busy", 32'(bus.out_busy), 32'd1);
      chk("mul.idle_tag", 32'(bus.out_cdb_rob_tag), 32'd0);
      if (j == freeze_at) begin
        ena = 1'b0;
        repeat (freeze_len) begin
          step();
          chk("mul.frozen_busy", 32'(bus.out_busy), 32'd1);
        end
        ena = 1'b1;
      end
      step();
    end
    chk("mul.busy_drop", 32'(bus.out_busy), 32'd0);
    chk("mul.tag", 32'(bus.out_cdb_rob_tag), 32'(tag));
    chk("mul.data", bus.out_cdb_data, e.data);
    chk("mul.br_valid", 32'(bus.out_br_valid), 32'd0);
  endtask
`endif

  initial begin
    exp_t e;
    op_t  op;
    logic [31:0] vj, vk, imm, pc;
    logic [4:0]  tag;

    // Reset
    drive(OP_NOP, 0, 0, 0, 0, 0);
    repeat (3) step();
    rst = 1'b0;
    chk("rst.tag", 32'(bus.out_cdb_rob_tag), 32'd0);
    chk("rst.data", bus.out_cdb_data, 32'd0);
    chk("rst.br_valid", 32'(bus.out_br_valid), 32'd0);
    chk("rst.br_taken", 32'(bus.out_br_taken), 32'd0);
    chk("rst.target", bus.out_br_target, 32'd0);
    chk("rst.busy", 32'(bus.out_busy), 32'd0);
    chk("rst.state", 32'(dbg_state), 32'(ST_IDLE));

    // Directed cases
    drive(OP_ADD, 5, 7, 0, 0, 3); step();
    chk("add.tag", 32'(bus.out_cdb_rob_tag), 32'd3);
    chk("add.data", bus.out_cdb_data, 32'd12);
    chk("add.br_valid", 32'(bus.out_br_valid), 32'd0);
    drive(OP_NOP, 0, 0, 0, 0, 0); step();
    chk("add.idle_tag", 32'(bus.out_cdb_rob_tag), 32'd0);
    drive(OP_SRAI, 32'h8000_0000, 0, 4, 0, 1); step();
    chk("srai.data", bus.out_cdb_data, 32'hF800_0000);
    drive(OP_SLTU, 1, 32'hFFFF_FFFF, 0, 0, 2); step();
    chk("sltu.data", bus.out_cdb_data, 32'd1);
    drive(OP_BLT, 32'hFFFF_FFFF, 0, 32'h20, 32'h100, 0); step();
    chk("blt.tag", 32'(bus.out_cdb_rob_tag), 32'd0);
    chk("blt.br_valid", 32'(bus.out_br_valid), 32'd1);
    chk("blt.taken", 32'(bus.out_br_taken), 32'd1);
    chk("blt.target", bus.out_br_target, 32'h120);
    drive(OP_BGE, 32'hFFFF_FFFF, 0, 32'h20, 32'h100, 0); step();
    chk("bge.br_valid", 32'(bus.out_br_valid), 32'd1);
    chk("bge.taken", 32'(bus.out_br_taken), 32'd0);
    chk("bge.target", bus.out_br_target, 32'h104);
    drive(OP_JALR, 32'h1001, 0, 2, 32'h40, 5); step();
    chk("jalr.tag", 32'(bus.out_cdb_rob_tag), 32'd5);
    chk("jalr.data", bus.out_cdb_data, 32'h44);
    chk("jalr.taken", 32'(bus.out_br_taken), 32'd1);
    chk("jalr.target", bus.out_br_target, 32'h1002);
    drive(6'd63, 1, 2, 3, 4, 7); step();
    chk("unknown.tag", 32'(bus.out_cdb_rob_tag), 32'd0);
    chk("unknown.br_valid", 32'(bus.out_br_valid), 32'd0);

    // Enable low: outputs hold, no idle-return, new op not sampled
    drive(OP_ADD, 1, 2, 0, 0, 4); step();
    ena = 1'b0;
    drive(OP_SUB, 9, 1, 0, 0, 9); step(); step();
    chk("hold.tag", 32'(bus.out_cdb_rob_tag), 32'd4);
    chk("hold.data", bus.out_cdb_data, 32'd3);
    ena = 1'b1;
    drive(OP_NOP, 0, 0, 0, 0, 0); step();
    chk("hold.release_tag", 32'(bus.out_cdb_rob_tag), 32'd0);

    // Randomized single-cycle ops, back to back
    for (int i = 0; i < 300; i++) begin
      op  = alu_ops[$urandom_range(0, alu_ops.size() - 1)];
`ifndef ALU_MUL_EN
      if ($urandom_range(0, 7) == 0) op = mul_ops[$urandom_range(0, 3)];
`endif
      vj  = pick_operand(); vk = pick_operand(); imm = pick_operand();
      pc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}; tag = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) vk = vj;
      e = ref_model(op, vj, vk, imm, pc, tag);
      drive(op, vj, vk, imm, pc, tag); step();
      check_out("rand", e);
    end
    drive(OP_NOP, 0, 0, 0, 0, 0); step();

`ifdef ALU_MUL_EN
    // MULH then an ADD issued only once busy has dropped
    run_mul(OP_MULH, 32'hFFFF_FFFF, 32'd2, 5'd6, -1, 0);
    drive(OP_ADD, 10, 20, 0, 0, 8); step();
    chk("post_mul.tag", 32'(bus.out_cdb_rob_tag), 32'd8);
    chk("post_mul.data", bus.out_cdb_data, 32'd30);
    drive(OP_NOP, 0, 0, 0, 0, 0);
    // Freeze mid-multiply stretches busy by the frozen cycles
    run_mul(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 5, 3);
    for (int i = 0; i < 8; i++)
      run_mul(mul_ops[$urandom_range(0, 3)], pick_operand(), pick_operand(),
              5'($urandom_range(1, 31)), -1, 0);
    // Reset at iteration 10 aborts the multiply
    drive(OP_MUL, 32'd3, 32'd4, 0, 0, 5'd12); step();
    bus.in_op = OP_NOP;
    repeat (10) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("abort.busy", 32'(bus.out_busy), 32'd0);
    chk("abort.state", 32'(dbg_state), 32'(ST_IDLE));
    for (int i = 0; i < 40; i++) begin
      step();
      chk("abort.no_bcast", 32'(bus.out_cdb_rob_tag), 32'd0);
    end
`else
    drive(OP_MULH, 32'hFFFF_FFFF, 32'd2, 0, 0, 6); step();
    chk("mul_off.tag", 32'(bus.out_cdb_rob_tag), 32'd6);
    chk("mul_off.data", bus.out_cdb_data, 32'd0);
    chk("mul_off.busy", 32'(bus.out_busy), 32'd0);
    drive(OP_NOP, 0, 0, 0, 0, 0); step();
    chk("mul_off.idle", 32'(bus.out_cdb_rob_tag), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL timeout: observed no completion expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
